// File: rtl/mem_req_ctrl_if.sv
// Bus between the MEM-stage request controller and the pipeline/data memory.
// slave is the controller's view; master is the pipeline/memory side.
interface mem_req_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              dREN_i;
  logic              dWEN_i;
  logic [DATA_W-1:0] aluout_i;
  logic [DATA_W-1:0] rdat2_i;
  logic              halt_i;
  logic              dhit;
  logic [DATA_W-1:0] dmemload;
  logic              dmemREN;
  logic              dmemWEN;
  logic [DATA_W-1:0] dmemaddr;
  logic [DATA_W-1:0] dmemstore;
  logic              pipe_EN;
  logic [DATA_W-1:0] load_o;
  logic              halt_o;
  logic              timeout_o;
  logic              proto_err_o;

  modport slave (
    input  dREN_i, dWEN_i, aluout_i, rdat2_i, halt_i, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, pipe_EN, load_o,
           halt_o, timeout_o, proto_err_o
  );

  modport master (
    output dREN_i, dWEN_i, aluout_i, rdat2_i, halt_i, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, pipe_EN, load_o,
           halt_o, timeout_o, proto_err_o
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// MEM-stage data memory request controller: IDLE -> ACCESS -> COMPLETE,
// stalling the pipeline until memory answers, with sticky halt/timeout/protocol flags.
module mem_req_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic           CLK,
  input logic           nRST,
  mem_req_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  localparam bit          TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [31:0] TIMEOUT_U  = TIMEOUT;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] store_reg, store_next;
  logic [DATA_W-1:0] load_reg, load_next;
  logic              is_wr_reg, is_wr_next;
  logic              halt_reg, halt_next;
  logic              timeout_reg, timeout_next;
  logic              proto_reg, proto_next;
  logic [7:0]        wait_reg, wait_next;
  logic              req;
  logic              ren;
  logic              wen;
  logic              pipe_en;

  assign req = bus.dREN_i | bus.dWEN_i;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      store_reg   <= '0;
      load_reg    <= '0;
      is_wr_reg   <= 1'b0;
      halt_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      proto_reg   <= 1'b0;
      wait_reg    <= 8'd0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      store_reg   <= store_next;
      load_reg    <= load_next;
      is_wr_reg   <= is_wr_next;
      halt_reg    <= halt_next;
      timeout_reg <= timeout_next;
      proto_reg   <= proto_next;
      wait_reg    <= wait_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    store_next   = store_reg;
    load_next    = load_reg;
    is_wr_next   = is_wr_reg;
    halt_next    = halt_reg;
    timeout_next = timeout_reg;
    proto_next   = proto_reg;
    wait_next    = wait_reg;
    ren          = 1'b0;
    wen          = 1'b0;
    pipe_en      = 1'b0;

    case (state_reg)
      IDLE: begin
        // A halted core parks here with the pipeline frozen and requests ignored.
        if (!halt_reg) begin
          pipe_en = ~req;
          if (req) begin
            state_next = ACCESS;
            addr_next  = bus.aluout_i;
            store_next = bus.rdat2_i;
            is_wr_next = bus.dWEN_i;
            wait_next  = 8'd0;
            if (bus.dREN_i && bus.dWEN_i) begin
              proto_next = 1'b1;
            end
          end else if (bus.halt_i) begin
            halt_next = 1'b1;
          end
        end
      end

      ACCESS: begin
        ren = ~is_wr_reg;
        wen = is_wr_reg;
        if (bus.dhit) begin
          state_next = COMPLETE;
          if (!is_wr_reg) begin
            load_next = bus.dmemload;
          end
        end else begin
          // Timeout only flags the stall; the access keeps waiting for dhit.
          if (wait_reg != 8'hFF) begin
            wait_next = wait_reg + 8'd1;
          end
          if (TIMEOUT_EN && ({24'd0, wait_next} == TIMEOUT_U)) begin
            timeout_next = 1'b1;
          end
        end
      end

      COMPLETE: begin
        pipe_en    = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.dmemREN     = ren;
  assign bus.dmemWEN     = wen;
  assign bus.dmemaddr    = addr_reg;
  assign bus.dmemstore   = store_reg;
  assign bus.pipe_EN     = pipe_en;
  assign bus.load_o      = load_reg;
  assign bus.halt_o      = halt_reg;
  assign bus.timeout_o   = timeout_reg;
  assign bus.proto_err_o = proto_reg;
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl: the driver plays pipeline and memory and queues
// expected accesses; a negedge monitor pops and checks each access as the DUT presents it.
module tb_mem_req_ctrl;
  localparam int TIMEOUT = 4;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
    bit          proto;
    bit          to_before;
    bit          to_after;
    int          lat;
  } exp_t;

  logic CLK;
  logic nRST;

  mem_req_ctrl_if #(.DATA_W(32)) bus ();

  mem_req_ctrl #(.DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model state (what the spec says the sticky outputs must be).
  logic [31:0] m_load    = 32'd0;
  bit          m_proto   = 1'b0;
  bit          m_timeout = 1'b0;
  bit          exp_halt  = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t        cur;
  bit          in_acc = 1'b0;
  int          nacc   = 0;
  logic [31:0] hold_addr = 32'd0, hold_store = 32'd0, hold_load = 32'd0;

  initial begin
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        chk1("rst_dmemREN", bus.dmemREN, 1'b0);
        chk1("rst_dmemWEN", bus.dmemWEN, 1'b0);
        chk32("rst_dmemaddr", bus.dmemaddr, 32'd0);
        chk32("rst_dmemstore", bus.dmemstore, 32'd0);
        chk32("rst_load_o", bus.load_o, 32'd0);
        chk1("rst_halt_o", bus.halt_o, 1'b0);
        chk1("rst_timeout_o", bus.timeout_o, 1'b0);
        chk1("rst_proto_err_o", bus.proto_err_o, 1'b0);
        in_acc = 1'b0;
        hold_addr = 32'd0; hold_store = 32'd0; hold_load = 32'd0;
      end else if (bus.dmemREN || bus.dmemWEN) begin
        if (!in_acc) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: ren=%b wen=%b required no strobe at %0t",
                     bus.dmemREN, bus.dmemWEN, $time);
          end else begin
            cur = exp_q.pop_front();
            in_acc = 1'b1;
            nacc = 0;
            chk1("strobe_wen", bus.dmemWEN, cur.wr);
            chk1("strobe_ren", bus.dmemREN, !cur.wr);
            hold_addr = cur.addr;
            hold_store = cur.store;
          end
        end
        if (in_acc) begin
          nacc++;
          chk32("access_addr", bus.dmemaddr, cur.addr);
          chk32("access_store", bus.dmemstore, cur.store);
          chk1("access_pipe_EN", bus.pipe_EN, 1'b0);
          chk1("access_timeout", bus.timeout_o,
               cur.to_before || (nacc - 1 >= TIMEOUT));
        end
      end else if (in_acc) begin
        chk32("latency", 32'(nacc), 32'(cur.lat));
        chk1("complete_pipe_EN", bus.pipe_EN, 1'b1);
        chk32("complete_load_o", bus.load_o, cur.load);
        chk1("complete_proto", bus.proto_err_o, cur.proto);
        chk1("complete_timeout", bus.timeout_o, cur.to_after);
        hold_load = cur.load;
        in_acc = 1'b0;
      end else begin
        chk1("idle_pipe_EN", bus.pipe_EN, !(bus.dREN_i || bus.dWEN_i) && !exp_halt);
        chk1("idle_halt_o", bus.halt_o, exp_halt);
        chk32("idle_addr_hold", bus.dmemaddr, hold_addr);
        chk32("idle_store_hold", bus.dmemstore, hold_store);
        chk32("idle_load_hold", bus.load_o, hold_load);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic noise();
    bus.dhit     = 1'($urandom_range(0, 1));
    bus.dmemload = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.dREN_i = 1'b0;
      bus.dWEN_i = 1'b0;
      noise();
      @(posedge CLK); #1;
    end
  endtask

  // lat = ACCESS cycle (1-based) in which memory answers with dhit.
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] ldata, input int lat);
    exp_t e;
    e.wr = wr;
    e.addr = addr;
    e.store = data;
    if (rd && wr) m_proto = 1'b1;
    if (!wr) m_load = ldata;
    e.load = m_load;
    e.proto = m_proto;
    e.to_before = m_timeout;
    if (lat - 1 >= TIMEOUT) m_timeout = 1'b1;
    e.to_after = m_timeout;
    e.lat = lat;
    exp_q.push_back(e);

    bus.dREN_i = rd;
    bus.dWEN_i = wr;
    bus.aluout_i = addr;
    bus.rdat2_i = data;
    noise();
    @(posedge CLK); #1;
    for (int k = 1; k <= lat; k++) begin
      bus.dhit = (k == lat);
      bus.dmemload = (k == lat) ? ldata : $urandom;
      @(posedge CLK); #1;
    end
    noise();
    @(posedge CLK); #1;
    bus.dREN_i = 1'b0;
    bus.dWEN_i = 1'b0;
  endtask

  task automatic model_reset();
    m_load = 32'd0;
    m_proto = 1'b0;
    m_timeout = 1'b0;
    exp_halt = 1'b0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    model_reset();
    bus.dREN_i = 1'b0;
    bus.dWEN_i = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  task automatic abort_access(input logic [31:0] addr);
    exp_t e;
    e.wr = 1'b0;
    e.addr = addr;
    e.store = $urandom;
    e.load = m_load;
    e.proto = m_proto;
    e.to_before = m_timeout;
    e.to_after = m_timeout;
    e.lat = 0;
    exp_q.push_back(e);
    bus.dREN_i = 1'b1;
    bus.dWEN_i = 1'b0;
    bus.aluout_i = addr;
    bus.rdat2_i = e.store;
    @(posedge CLK); #1;
    bus.dhit = 1'b0;
    @(posedge CLK); #1;
    bus.dhit = 1'b0;
    // Reset lands mid-cycle; the monitor samples before the next rising edge.
    #1 do_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          rd, wr;
    int          r;
    logic [31:0] ldata;
    nRST = 1'b0;
    bus.dREN_i = 1'b0;
    bus.dWEN_i = 1'b0;
    bus.aluout_i = 32'd0;
    bus.rdat2_i = 32'd0;
    bus.halt_i = 1'b0;
    bus.dhit = 1'b0;
    bus.dmemload = 32'd0;
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;
    idle(2);

    do_access(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2);
    do_access(1'b0, 1'b1, 32'h200, 32'h12345678, 32'hCAFEF00D, 1);
    idle(1);
    do_access(1'b1, 1'b1, 32'h300, 32'hA5A5A5A5, 32'h11111111, 1);
    do_access(1'b1, 1'b0, 32'h304, 32'h0, 32'h22222222, 3);
    do_access(1'b1, 1'b0, 32'h400, 32'h0, 32'h33333333, 7);
    do_access(1'b0, 1'b1, 32'h404, 32'h44444444, 32'h0, 1);
    idle(1);
    abort_access(32'h500);
    do_access(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2);
    // Halt while a request is pending must not latch halt.
    bus.halt_i = 1'b1;
    do_access(1'b0, 1'b1, 32'h600, 32'h66666666, 32'h0, 2);
    bus.halt_i = 1'b0;

    for (int i = 0; i < 45; i++) begin
      if (i % 15 == 14) do_reset();
      r = $urandom_range(0, 7);
      rd = (r <= 3) || (r == 7);
      wr = (r >= 4);
      ldata = $urandom;
      do_access(rd, wr, $urandom, $urandom, ldata, $urandom_range(1, 7));
      idle($urandom_range(0, 2));
    end

    bus.halt_i = 1'b1;
    bus.dREN_i = 1'b0;
    bus.dWEN_i = 1'b0;
    @(posedge CLK); #1;
    exp_halt = 1'b1;
    bus.halt_i = 1'b0;
    bus.dREN_i = 1'b1;
    bus.aluout_i = 32'h700;
    repeat (4) begin noise(); @(posedge CLK); #1; end
    bus.dWEN_i = 1'b1;
    repeat (3) begin noise(); @(posedge CLK); #1; end
    idle(2);

    checks++;
    if (exp_q.size() != 0 || in_acc) begin
      errors++;
      $display("FAIL drain: %0d accesses pending, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, width of the data word and the address.
REQ-002 Parameter TIMEOUT, default 255, number of wait cycles before the timeout flag is raised; a value of 0 disables the timeout.
REQ-003 CLK  in  1  clock; all state updates on the rising edge.
REQ-004 nRST  in  1  reset; asynchronous, active-low.
REQ-005 dREN_i  in  1  load request from the EX/MEM stage register.
REQ-006 dWEN_i  in  1  store request from the EX/MEM stage register.
REQ-007 aluout_i  in  DATA_W  byte address of the access.
REQ-008 rdat2_i  in  DATA_W  store data.
REQ-009 halt_i  in  1  halt instruction is present in MEM.
REQ-010 dhit  in  1  memory response: the access completed this cycle.
REQ-011 dmemload  in  DATA_W  load data from memory; valid when dhit=1.
REQ-012 dmemREN  out  1  read strobe to memory.
REQ-013 dmemWEN  out  1  write strobe to memory.
REQ-014 dmemaddr  out  DATA_W  address driven to memory.
REQ-015 dmemstore  out  DATA_W  store data driven to memory.
REQ-016 pipe_EN  out  1  enable for the EX/MEM and MEM/WB registers; 0 stalls the pipeline.
REQ-017 load_o  out  DATA_W  load data captured from memory, passed to the writeback path.
REQ-018 halt_o  out  1  sticky halt indication.
REQ-019 timeout_o  out  1  sticky flag: memory failed to respond within TIMEOUT cycles.
REQ-020 proto_err_o  out  1  sticky flag: dREN_i and dWEN_i were asserted together.

Function
REQ-021 The state machine SHALL have three states: IDLE, ACCESS and COMPLETE.
REQ-022 IDLE: if dREN_i or dWEN_i is high, the block SHALL go to ACCESS on the next edge and latch aluout_i, rdat2_i and the access type; otherwise it SHALL stay in IDLE.
REQ-023 In IDLE, pipe_EN SHALL equal the inverse of (dREN_i or dWEN_i), so the pipeline stalls in the same cycle a request appears.
REQ-024 ACCESS: dmemREN or dmemWEN SHALL be driven high, according to the latched type.
REQ-025 In ACCESS, dmemaddr and dmemstore SHALL come from the latched values.
REQ-026 In ACCESS, pipe_EN SHALL be 0.
REQ-027 ACCESS with dhit=1: the block SHALL go to COMPLETE, and for a load it SHALL capture dmemload into load_o on that edge.
REQ-028 COMPLETE SHALL last exactly one cycle, with pipe_EN=1 and both strobes low, and then return to IDLE.
REQ-029 A new request SHALL only be accepted in IDLE, which gives a minimum of 3 cycles from request to pipeline advance when dhit arrives in the first ACCESS cycle.
REQ-030 When dhit arrives in the first ACCESS cycle, the sequence SHALL be: request cycle (IDLE), ACCESS, COMPLETE.
REQ-031 When dREN_i and dWEN_i are both high, the block SHALL perform a write only and set proto_err_o.
REQ-032 A 8-bit wait counter SHALL clear on entry to ACCESS, increment each ACCESS cycle with dhit=0, and saturate at 255.
REQ-033 When TIMEOUT is nonzero and the wait counter reaches TIMEOUT, the block SHALL set timeout_o and stay in ACCESS.
REQ-034 A timeout SHALL NOT abort the access.
REQ-035 dhit outside ACCESS SHALL be ignored and SHALL NOT update load_o.
REQ-036 halt_o SHALL set on any edge where halt_i=1 and the state is IDLE with no request pending.
REQ-037 Once set, halt_o SHALL stay set until reset.
REQ-038 Once halt_o=1, new requests SHALL be ignored, both strobes SHALL stay low, and pipe_EN SHALL be 0.
REQ-039 dmemaddr and dmemstore SHALL hold their last latched values outside ACCESS.
REQ-040 load_o SHALL hold its value until the next load completes.

Reset
REQ-041 While nRST=0, and immediately on its assertion, the block SHALL return to IDLE.
REQ-042 On reset, dmemREN, dmemWEN, dmemaddr, dmemstore, load_o, halt_o, timeout_o, proto_err_o and the wait counter SHALL all be 0.
REQ-043 Reset in the middle of an access SHALL drop the strobes asynchronously and discard the access.
REQ-044 After reset is released, pipe_EN SHALL follow REQ-023.

Verification
REQ-045 Load: dREN_i=1, aluout_i=0x100, and memory returns dhit=1 with 0xDEADBEEF in the second cycle -> dmemREN high for 2 cycles, dmemaddr=0x100, load_o=0xDEADBEEF, pipe_EN low for 3 cycles and then high for 1.
REQ-046 Store: dWEN_i=1, aluout_i=0x200, rdat2_i=0x12345678, and dhit=1 in the first ACCESS cycle -> dmemWEN for 1 cycle, dmemstore=0x12345678, load_o unchanged.
REQ-047 Both requests: dREN_i=dWEN_i=1 -> only dmemWEN asserts, proto_err_o=1, and the flag stays set across later accesses.
REQ-048 Timeout: TIMEOUT=4 and dhit held low -> timeout_o rises after 4 ACCESS cycles; a later dhit=1 completes the access normally.
REQ-049 Reset mid-access: nRST pulsed low during ACCESS -> strobes drop before the next edge and all outputs are 0; a subsequent request behaves as in REQ-045.
REQ-050 Halt: halt_i=1 in IDLE -> halt_o=1 on the next edge; a later dREN_i=1 produces no strobe and pipe_EN stays 0.
